// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: the receiver drives data/valid and
// the error pulses, and the consumer drives ready.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    modport master (output data, valid, frame_err, overrun, input ready);
    modport slave  (input data, valid, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit is checked at mid-bit, data is sampled LSB first,
// and bytes are delivered on a valid/ready handshake with overrun/framing pulses.
module uart_rx #(
    parameter int Clock = 50,
    parameter int Baud  = 115200
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rx,
    uart_rx_if.master bus
);
    localparam int unsigned BIT_CYC  = int'((longint'(Clock) * 64'd1000000) / longint'(Baud));
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned TW       = $clog2(BIT_CYC + 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_CYC - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYC - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_nxt;
    logic          rx_meta, rxs;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          deliver, bad_stop;
    logic [7:0]    data_q;
    logic          valid_q, frame_err_q, overrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            idx   <= idx_nxt;
            shift <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idx_nxt   = idx;
        shift_nxt = shift;
        deliver   = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    timer_nxt = '0;
                end
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_nxt = '0;
                    if (!rxs) begin
                        state_nxt = DATA;
                        idx_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_nxt      = '0;
                    shift_nxt[idx] = rxs;
                    if (idx == 3'd7) state_nxt = STOP;
                    else             idx_nxt   = idx + 3'd1;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            STOP: begin
                if (timer == BIT_LAST) begin
                    timer_nxt = '0;
                    if (rxs) begin
                        deliver   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        bad_stop  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A delivery that coincides with a transfer replaces the byte being consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= bad_stop;
            overrun_q   <= 1'b0;
            if (deliver) begin
                if (!valid_q || bus.ready) begin
                    data_q  <= shift;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud: table of framed bytes plus
// hand-timed sequences for latency, glitch, overrun, same-cycle handoff and reset.
module tb_uart_rx;
    localparam int BIT  = 434;
    localparam int HALF = 217;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_rx_if bus();

    uart_rx #(.Clock(50), .Baud(115200)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int         cyc = 0;
    int         fall_cyc = 0;
    int         rise_cyc = 0;
    int         xfer_cnt = 0;
    logic [7:0] xfer_data = 8'h00;
    int         vcyc = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    int         pulse_viol = 0;
    logic       valid_d = 1'b0;
    logic       ferr_d = 1'b0;
    logic       ovr_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid && bus.ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            xfer_data <= bus.data;
        end
        if (bus.valid && !valid_d) rise_cyc <= cyc;
        if (bus.valid) vcyc <= vcyc + 1;
        if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (bus.overrun) ovr_cnt <= ovr_cnt + 1;
        if ((bus.frame_err && ferr_d) || (bus.overrun && ovr_d)) pulse_viol <= pulse_viol + 1;
        valid_d <= bus.valid;
        ferr_d  <= bus.frame_err;
        ovr_d   <= bus.overrun;
    end

    typedef struct {
        logic [7:0] din;
        logic       stop;
        int         low_after;
        int         exp_xfers;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        tick();
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (BIT) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) tick();
        end
        rx = stop;
        repeat (BIT) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, f0, o0, v0, lat;

        vecs[0] = '{8'h00, 1'b1, 0,       1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 0,       1, 8'hFF, 0};
        vecs[2] = '{8'h3C, 1'b0, 2 * BIT, 0, 8'hFF, 1};
        vecs[3] = '{8'h55, 1'b1, 0,       1, 8'h55, 0};
        vecs[4] = '{8'h81, 1'b1, 0,       1, 8'h81, 0};

        bus.ready = 1'b1;
        repeat (3) tick();
        check("reset_data", int'(bus.data), 0);
        check("reset_valid", int'(bus.valid), 0);
        check("reset_frame_err", int'(bus.frame_err), 0);
        check("reset_overrun", int'(bus.overrun), 0);
        rst = 1'b0;

        // First byte right after reset, with latency and valid width.
        x0 = xfer_cnt; v0 = vcyc;
        send_byte(8'hA5, 1'b1);
        repeat (HALF) tick();
        lat = rise_cyc - fall_cyc;
        n_cmp++;
        if (lat < 4120 || lat > 4126) begin
            n_bad++;
            $display("FAIL latency_A5: got %0d clk, expected 4120..4126 clk", lat);
        end
        check("A5_xfers", xfer_cnt - x0, 1);
        check("A5_data", int'(xfer_data), 'hA5);
        check("A5_valid_cycles", vcyc - v0, 1);

        // Short low pulse must be rejected as a glitch.
        x0 = xfer_cnt; f0 = ferr_cnt;
        tick();
        rx = 1'b0;
        repeat (100) tick();
        rx = 1'b1;
        repeat (BIT) tick();
        check("glitch_xfers", xfer_cnt - x0, 0);
        check("glitch_frame_err", ferr_cnt - f0, 0);
        check("glitch_valid", int'(bus.valid), 0);

        for (int i = 0; i < 5; i++) begin
            x0 = xfer_cnt; f0 = ferr_cnt;
            send_byte(vecs[i].din, vecs[i].stop);
            repeat (vecs[i].low_after) tick();
            rx = 1'b1;
            repeat (BIT) tick();
            check($sformatf("vec%0d_xfers", i), xfer_cnt - x0, vecs[i].exp_xfers);
            check($sformatf("vec%0d_data", i), int'(bus.data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_frame_err", i), ferr_cnt - f0, vecs[i].exp_ferr);
        end

        // Back-pressure: second byte is dropped with one overrun pulse.
        bus.ready = 1'b0;
        o0 = ovr_cnt; x0 = xfer_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("ovr_data", int'(bus.data), 'h11);
        check("ovr_valid", int'(bus.valid), 1);
        check("ovr_pulses", ovr_cnt - o0, 1);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        check("ovr_drain_valid", int'(bus.valid), 0);
        check("ovr_drain_data", int'(xfer_data), 'h11);
        check("ovr_drain_xfers", xfer_cnt - x0, 1);

        // ready lands exactly on the stop-sample cycle of the next byte.
        send_byte(8'h66, 1'b1);
        repeat (HALF) tick();
        o0 = ovr_cnt; x0 = xfer_cnt;
        fork
            send_byte(8'h77, 1'b1);
            begin
                tick();
                repeat (4125) tick();
                bus.ready = 1'b1;
                tick();
                bus.ready = 1'b0;
            end
        join
        check("handoff_xfers", xfer_cnt - x0, 1);
        check("handoff_xfer_data", int'(xfer_data), 'h66);
        check("handoff_data", int'(bus.data), 'h77);
        check("handoff_valid", int'(bus.valid), 1);
        check("handoff_overrun", ovr_cnt - o0, 0);
        bus.ready = 1'b1;
        tick();
        check("handoff_drain_valid", int'(bus.valid), 0);

        // Reset in the middle of the DATA state of 8'hF0.
        tick();
        rx = 1'b0;
        repeat (4 * BIT) tick();
        rst = 1'b1;
        #1;
        check("async_rst_data", int'(bus.data), 0);
        check("async_rst_valid", int'(bus.valid), 0);
        check("async_rst_frame_err", int'(bus.frame_err), 0);
        rx = 1'b1;
        x0 = xfer_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2 * BIT) tick();
        check("post_rst_xfers", xfer_cnt - x0, 0);
        check("post_rst_frame_err", ferr_cnt - f0, 0);
        check("post_rst_overrun", ovr_cnt - o0, 0);
        send_byte(8'h0F, 1'b1);
        repeat (HALF) tick();
        check("post_rst_0F_xfers", xfer_cnt - x0, 1);
        check("post_rst_0F_data", int'(xfer_data), 'h0F);

        check("pulse_width", pulse_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter Clock, default 50, giving the system clock frequency in MHz.
REQ-002 The block SHALL have parameter Baud, default 115200, giving the serial bit rate in bit/s.
REQ-003 The block SHALL derive BIT_CYC = (Clock*1000000)/Baud using integer division, which is 434 at the defaults, and HALF_CYC = BIT_CYC/2, which is 217.
REQ-004 clk  input  1  system clock; the block SHALL have one clock, and all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset; the block SHALL treat it as asynchronous and active-high.
REQ-006 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-007 data  output  8  received byte.
REQ-008 valid  output  1  data holds an unconsumed byte.
REQ-009 ready  input  1  consumer accepts data; a transfer SHALL occur on any cycle where valid and ready are both 1.
REQ-010 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer before any use; the synchronized value is rxs.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-014 IDLE: when rxs=0, the FSM SHALL go to START and clear the bit-timer.
REQ-015 START: after HALF_CYC cycles the FSM SHALL sample rxs.
  - rxs=0: go to DATA and clear the timer and bit index.
  - rxs=1: treat as a glitch and return to IDLE with no output activity.
REQ-016 DATA: every BIT_CYC cycles the FSM SHALL sample rxs into shift bit[index], LSB first.
  - After the 8th sample, go to STOP.
REQ-017 STOP: after BIT_CYC cycles the FSM SHALL sample rxs.
  - rxs=1: deliver the byte (REQ-019) and return to IDLE.
  - rxs=0: pulse frame_err for 1 cycle, discard the byte and go to WAIT_HIGH.
REQ-018 WAIT_HIGH: the FSM SHALL remain until rxs=1, then go to IDLE; a held break SHALL NOT produce repeated bytes or repeated frame_err pulses.
REQ-019 Delivery: on the stop-sample cycle, data SHALL be loaded and valid SHALL be set to 1 on the next edge.
REQ-020 valid SHALL clear on the edge following a valid&&ready cycle, unless a new byte is delivered on that same cycle.
REQ-021 data SHALL remain stable while valid=1 and no transfer occurs.
REQ-022 Delivery while valid=1 and ready=0: the new byte SHALL be dropped, data SHALL keep the old byte, valid SHALL remain 1, and overrun SHALL pulse for 1 cycle.
REQ-023 Delivery on the same cycle as valid&&ready: the new byte SHALL load, valid SHALL stay 1, and overrun SHALL remain 0.
REQ-024 The bit-timer SHALL count from 0 to its terminal value (HALF_CYC-1 or BIT_CYC-1) and restart at 0.
  - The timer SHALL be wide enough for BIT_CYC with no wrap at any legal parameter value.
REQ-025 frame_err and overrun SHALL never be asserted for more than one consecutive cycle per event.
REQ-026 The receiver SHALL keep receiving regardless of ready; back-pressure SHALL NOT stall the FSM.

Reset
REQ-027 While rst=1, all flops SHALL take their reset values immediately, independent of clk:
  - state = IDLE
  - synchronizer flops = 1
  - timer, index and shift register = 0
  - data = 8'h00
  - valid = 0, frame_err = 0, overrun = 0
REQ-028 Reset asserted mid-frame SHALL abort the frame with no valid, frame_err or overrun pulse.
  - After release, the FSM SHALL wait in IDLE for the next falling edge; rx low at release SHALL start reception only via the normal START check.
REQ-029 After rst deasserts, the first reception SHALL require no extra initialization cycles.

Verification
REQ-030 Defaults, ready=1: send 8'hA5 with 1 start bit, 8 data bits and 1 stop bit at 434 clk/bit. Required response: data=8'hA5 and valid=1 for exactly 1 cycle, within 9.5 bit times (4123 clk) +/-3 clk of the rx falling edge.
REQ-031 Hold rx low for 100 clk, then return it high. Required response: no valid, no frame_err, and the FSM back in IDLE.
REQ-032 Send 8'h3C with the stop bit forced to 0, then hold rx low for 2 bit times, then send 8'h55 normally. Required response: exactly 1 frame_err pulse, no valid for 8'h3C, then valid with data=8'h55.
REQ-033 With ready=0, send 8'h11 then 8'h22 back-to-back. Required response: data stays 8'h11, valid stays 1, and 1 overrun pulse at the 8'h22 stop sample. Then raise ready for 1 cycle; required response: valid drops.
REQ-034 Time ready=1 to coincide with the stop-sample cycle of 8'h77 while 8'h66 is pending. Required response: 8'h66 transfers, data becomes 8'h77, valid remains 1, and overrun stays 0.
REQ-035 Assert rst during the DATA state of 8'hF0. Required response: outputs go to reset values asynchronously, and no valid or frame_err follows. A subsequent 8'h0F SHALL be received correctly.
